addsub_result_scan: RTL and testbench

- Downstream display stage for the 4-bit add/subtract datapath.
- Captures operands, the add/sub mode, the 4-bit result and the carry-out on a load event.
- Time-multiplexes them onto a 4-digit common-anode 7-segment display: a, b, status glyph, result.
- Sits between the adder/subtractor outputs and the board display pins.

---
 rtl/addsub_result_scan_pkg.sv | 42 ++++
 rtl/addsub_result_scan_hex.sv | 31 +++
 rtl/addsub_result_scan.sv | 127 ++++++++++++
 tb/tb_addsub_result_scan.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_result_scan_pkg.sv
// Shared constants and types for the add/sub result display scanner.
package addsub_result_scan_pkg;

  localparam int IDX_W = 2;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_N     = 7'h54;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Active-low digit enables; bit3 drives the leftmost digit.
  localparam logic [3:0] AN_SUM  = 4'b1110;
  localparam logic [3:0] AN_STAT = 4'b1101;
  localparam logic [3:0] AN_B    = 4'b1011;
  localparam logic [3:0] AN_A    = 4'b0111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef enum logic [IDX_W-1:0] {
    DIG_SUM  = 2'd0,
    DIG_STAT = 2'd1,
    DIG_B    = 2'd2,
    DIG_A    = 2'd3
  } digit_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] sum;
    logic       cout1;
  } capture_t;

  function automatic digit_e next_digit(input digit_e d);
    unique case (d)
      DIG_SUM:  return DIG_STAT;
      DIG_STAT: return DIG_B;
      DIG_B:    return DIG_A;
      default:  return DIG_SUM;
    endcase
  endfunction

endpackage

// File: rtl/addsub_result_scan_hex.sv
// Nibble to active-high 7-segment glyph ({g,f,e,d,c,b,a}), purely combinational.
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    // NOTE: default first so no path leaves glyph unassigned (no latch).
    glyph = 7'h00;
    unique case (nibble)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      4'hF: glyph = 7'h71;
      default: glyph = 7'h00;
    endcase
  end

endmodule

// File: rtl/addsub_result_scan.sv
// Captures add/sub operands and result on a load edge and scans them onto a
// 4-digit common-anode display: a, b, status glyph, result (left to right).
module addsub_result_scan
  import addsub_result_scan_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  input  logic [3:0] sum,
  input  logic       cout1,
  input  logic       load,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       valid
);

  localparam int PRESC_W = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2) begin : g_bad_div
    $error("SCAN_DIV must be at least 2");
  end
  if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
    $error("BLANK_CYC must be less than SCAN_DIV");
  end

  logic [PRESC_W-1:0] presc;
  digit_e             idx;
  logic               load_d;
  logic               cap_en;
  capture_t           cap;

  logic               presc_wrap;
  logic               in_blank;
  logic [3:0]         nibble;
  logic [6:0]         hex_glyph;
  logic [6:0]         glyph_nxt;
  logic [3:0]         an_nxt;

  assign cap_en     = load & ~load_d;
  assign presc_wrap = (presc == PRESC_W'(SCAN_DIV - 1));
  assign in_blank   = (presc < PRESC_W'(BLANK_CYC));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, keeping capture and digit advance in lockstep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc  <= '0;
      idx    <= DIG_SUM;
      load_d <= 1'b0;
      cap    <= '0;
      valid  <= 1'b0;
    end else begin
      load_d <= load;
      if (presc_wrap) begin
        presc <= '0;
        idx   <= next_digit(idx);
      end else begin
        presc <= presc + PRESC_W'(1);
      end
      if (cap_en) begin
        cap   <= '{a: a, b: b, sub: sub, sum: sum, cout1: cout1};
        valid <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble = cap.sum;
    unique case (idx)
      DIG_B:   nibble = cap.b;
      DIG_A:   nibble = cap.a;
      default: nibble = cap.sum;
    endcase
  end

  hex_to_7seg u_hex (
    .nibble (nibble),
    .glyph  (hex_glyph)
  );

  // Output mux works only from registered state, so inputs never reach the pins
  // combinationally and new data always lands together with its digit index.
  always_comb begin
    an_nxt    = AN_OFF;
    glyph_nxt = GLYPH_BLANK;
    unique case (idx)
      DIG_SUM: begin
        an_nxt    = AN_SUM;
        glyph_nxt = hex_glyph;
      end
      DIG_STAT: begin
        an_nxt = AN_STAT;
        if (!cap.sub && cap.cout1)      glyph_nxt = GLYPH_C;
        else if (cap.sub && !cap.cout1) glyph_nxt = GLYPH_N;
        else                            glyph_nxt = GLYPH_BLANK;
      end
      DIG_B: begin
        an_nxt    = AN_B;
        glyph_nxt = hex_glyph;
      end
      default: begin
        an_nxt    = AN_A;
        glyph_nxt = hex_glyph;
      end
    endcase
    if (!valid || in_blank) begin
      an_nxt    = AN_OFF;
      glyph_nxt = GLYPH_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 7'h7F;
      an_n  <= AN_OFF;
    end else begin
      seg_n <= ~glyph_nxt;
      an_n  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_addsub_result_scan.sv
// Scoreboard bench for addsub_result_scan: the driver queues the expected display
// word for every clock, a negedge monitor pops and compares.
module tb_addsub_result_scan;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b, sum;
  logic       sub, cout1, load;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       valid;

  addsub_result_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .sum   (sum),
    .cout1 (cout1),
    .load  (load),
    .seg_n (seg_n),
    .an_n  (an_n),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Hand-computed active-low segment words for each digit of one captured case.
  typedef struct {
    logic [6:0] seg_sum;
    logic [6:0] seg_stat;
    logic [6:0] seg_b;
    logic [6:0] seg_a;
  } disp_t;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       vld;
    string      tag;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    e = 0;
  bit    cur_valid = 0;
  bit    pending = 0;
  disp_t cur, pend;
  string phase = "reset";

  // a=5 b=3 add sum=8 cout=0
  localparam disp_t D_ADD    = '{7'h00, 7'h7F, 7'h30, 7'h12};
  // a=2 b=5 sub sum=D cout=0 (borrow)
  localparam disp_t D_BORROW = '{7'h21, 7'h2B, 7'h12, 7'h24};
  // a=F b=1 add sum=0 cout=1 (carry)
  localparam disp_t D_CARRY  = '{7'h40, 7'h46, 7'h79, 7'h0E};
  // a=9 b=6 sub sum=3 cout=1 (no borrow)
  localparam disp_t D_HELD   = '{7'h30, 7'h7F, 7'h02, 7'h10};
  // a=C b=7 add sum=3 cout=1
  localparam disp_t D_WRAP   = '{7'h30, 7'h46, 7'h78, 7'h46};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: queue the word the DUT must show after this edge, then move
  // inputs 1ns later so nothing races the edge.
  task automatic tick();
    exp_t ex;
    int   p, d;
    @(posedge clk);
    ex.tag = phase;
    ex.seg = 7'h7F;
    ex.an  = 4'hF;
    if (!rst_n) begin
      e = 0;
      cur_valid = 0;
      pending = 0;
      ex.vld = 1'b0;
    end else begin
      p = e % SCAN_DIV;
      d = (e / SCAN_DIV) % 4;
      e++;
      if (cur_valid && p >= BLANK_CYC) begin
        case (d)
          0: begin ex.an = 4'hE; ex.seg = cur.seg_sum;  end
          1: begin ex.an = 4'hD; ex.seg = cur.seg_stat; end
          2: begin ex.an = 4'hB; ex.seg = cur.seg_b;    end
          default: begin ex.an = 4'h7; ex.seg = cur.seg_a; end
        endcase
      end
      if (pending) begin
        cur = pend;
        cur_valid = 1;
        pending = 0;
      end
      ex.vld = cur_valid;
    end
    q.push_back(ex);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_pulse(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                            input logic [3:0] tsum, input logic tc, input disp_t exp_d);
    a = ta; b = tb; sub = ts; sum = tsum; cout1 = tc;
    load = 1'b1;
    pending = 1;
    pend = exp_d;
    tick();
    load = 1'b0;
  endtask

  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        ex = q.pop_front();
        check({ex.tag, "_seg_n"}, 32'(seg_n), 32'(ex.seg));
        check({ex.tag, "_an_n"},  32'(an_n),  32'(ex.an));
        check({ex.tag, "_valid"}, 32'(valid), 32'(ex.vld));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst_n = 1'b0;
    a = '0; b = '0; sub = 1'b0; sum = '0; cout1 = 1'b0; load = 1'b0;
    ticks(3);
    @(negedge clk); #1;
    rst_n = 1'b1;

    phase = "idle";
    ticks(40);

    phase = "add";
    load_pulse(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, D_ADD);
    ticks(34);

    phase = "borrow";
    load_pulse(4'h2, 4'h5, 1'b1, 4'hD, 1'b0, D_BORROW);
    ticks(34);

    phase = "carry";
    load_pulse(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, D_CARRY);
    ticks(34);

    // Held load: only the first-clock values may be captured.
    phase = "held";
    a = 4'h9; b = 4'h6; sub = 1'b1; sum = 4'h3; cout1 = 1'b1;
    load = 1'b1;
    pending = 1;
    pend = D_HELD;
    tick();
    a = 4'hA; b = 4'hE; sub = 1'b0; sum = 4'h8; cout1 = 1'b1;
    ticks(29);
    load = 1'b0;
    ticks(36);

    // Rising load edge on the clock where the prescaler wraps.
    phase = "wrap";
    while (e % SCAN_DIV != SCAN_DIV - 1) tick();
    load_pulse(4'hC, 4'h7, 1'b0, 4'h3, 1'b1, D_WRAP);
    ticks(34);

    // Asynchronous reset mid-slot while a digit is lit.
    phase = "async_rst";
    while (e % SCAN_DIV != 4) tick();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_seg_n", 32'(seg_n), 32'h7F);
    check("async_rst_an_n",  32'(an_n),  32'hF);
    check("async_rst_valid", 32'(valid), 32'h0);
    ticks(2);
    @(negedge clk); #1;
    rst_n = 1'b1;

    phase = "post_rst";
    ticks(40);

    phase = "reload";
    load_pulse(4'h5, 4'h3, 1'b0, 4'h8, 1'b0, D_ADD);
    ticks(34);

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
